uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the counterpart of the `uart` transmitter.
- Synchronises the asynchronous `rx` line and detects start bits.
- Samples each bit at mid-bit time using a divide-by-CDIV tick counter.
- Pushes good bytes into a small FIFO, drained by a downstream consumer over a valid/ready handshake. Loops back against `uart` in the system bench.

Parameters:
CDIV, 10, clocks per bit; even, >= 4
BUFFER_SIZE, 4, receive FIFO depth in bytes; power of 2, >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
data  output  8  byte at FIFO head
valid  output  1  FIFO not empty
ready  input  1  consumer accepts `data` this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: good byte dropped because FIFO full
busy  output  1  receiver state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, bit_cnt=0, rp=wp=0. Outputs: data=0, valid=0, frame_err=0, overrun=0, busy=0. Synchroniser flops preset to 1. Reset mid-frame abandons the partial byte; FIFO contents are lost.
- Synchroniser: 2 flops, rx -> rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP. cnt counts clocks within a bit; bit_cnt counts 0..7.
- IDLE: when rx_s=0 -> START, cnt=0.
- START: when cnt==CDIV/2-1, check rx_s.
  - rx_s=0: -> DATA, cnt=0, bit_cnt=0.
  - rx_s=1: glitch; -> IDLE, nothing reported.
- DATA: when cnt==CDIV-1, shift rx_s into shreg MSB (LSB-first on the wire) and reset cnt.
  - bit_cnt increments per sample.
  - After the 8th sample -> STOP, cnt=0.
- STOP: when cnt==CDIV-1, sample rx_s, then go to IDLE. Returning to IDLE at mid-stop-bit allows back-to-back frames with one stop bit.
  - rx_s=1: push shreg if FIFO not full or a pop occurs in the same cycle. Otherwise drop the byte and pulse overrun.
  - rx_s=0: pulse frame_err, no push. If rx stays low, IDLE immediately sees it as a new start.
- Latency: valid rises one clock after the stop-bit sample. From the rx falling edge this is 2 + CDIV/2 + 9*CDIV + 1 clocks (98 for CDIV=10), ±1.
- FIFO:
  - Pointers are log2(BUFFER_SIZE)+1 bits wide.
  - empty: rp==wp. full: MSBs differ and the rest are equal.
  - data = mem[rp] (first-word fall-through). Pop on valid && ready.
  - Simultaneous push and pop is legal at any fill level.
  - Pointers wrap naturally.
  - ready while valid=0 is ignored.
  - `data` is stable while valid && !ready.
- frame_err and overrun are never asserted in the same cycle. Both are registered.

Decomposition:
- Shared header `uart_defs.v`, used by both uart and uart_rx:
  - state encodings: IDLE=0, START=1, DATA=2, STOP=3
  - `UART_DBITS` = 8
  - clog2 helper macro
- The FIFO is the natural sub-module: `uart_fifo` (params WIDTH, DEPTH; ports push/pop/din/dout/full/empty). It is the same buffer the transmitter uses, so factor it out and share it.

Test Plan (CDIV=10, BUFFER_SIZE=4; bench drives rx through the bit timing of a `uart` instance):
- Reset: rst=0 mid-idle -> valid=0, busy=0, rp=wp=0, frame_err=0, overrun=0, state=IDLE.
- Single byte: frame 'g' (0x67) -> valid=1 with data=0x67 at 98±1 clocks after the start edge. ready=1 -> valid=0 the next clock.
- Glitch: rx low for 3 clocks then high -> busy rises, then returns to 0. valid and frame_err never assert.
- Framing error: 0x55 sent with stop bit=0 -> frame_err one-cycle pulse at the stop sample. valid stays 0; the receiver resynchronises and next byte 0x41 is received correctly.
- Overrun/back-to-back: ready=0, five frames 0x31..0x35 with one stop bit each.
  - 0x31..0x34 stored; overrun pulses once at the fifth stop sample.
  - Then ready=1 -> data sequence 0x31,0x32,0x33,0x34 on consecutive clocks, then valid=0.
- Reset mid-frame: rst=0 during bit 4 of 0xA5 -> busy=0 and valid=0 immediately. Next frame 0x5A is received intact.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encodings, frame width and a clog2 helper.
package uart_rx_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int unsigned UART_DBITS = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      rp;
    logic [AW:0]      wp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (rp == wp);
    assign full    = (rp[AW] != wp[AW]) && (rp[AW-1:0] == wp[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp <= '0;
            wp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= din;
                wp              <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a small receive FIFO.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CDIV        = 10,
    parameter int unsigned BUFFER_SIZE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned      CNT_W    = clog2(CDIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CDIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CDIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DBITS - 1);

    logic             rx_m;
    logic             rx_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             stop_sample;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign stop_sample = (state == STOP) && (cnt == CNT_LAST);
    assign push        = stop_sample && rx_s;
    assign pop         = valid && ready;
    assign valid       = !empty;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        frame_err <= !rx_s;
                        overrun   <= rx_s && full && !pop;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames on rx, checked against a queue-based model of an 8N1 receiver.
module tb_uart_rx;

    localparam int CDIV = 10;
    localparam int BUF  = 4;
    localparam int LAT  = 2 + CDIV / 2 + 9 * CDIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CDIV        (CDIV),
        .BUFFER_SIZE (BUF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake log, taken on the edge where the transfer actually happens.
    logic [7:0]  acc_q[$];
    int unsigned acc_cyc[$];
    always @(posedge clk) begin
        if (rst && valid && ready) begin
            acc_q.push_back(data);
            acc_cyc.push_back(cyc);
        end
    end

    int          fe_cnt = 0, ov_cnt = 0, long_pulse = 0, both = 0;
    int          valid_seen = 0, busy_seen = 0;
    int unsigned fe_cyc = 0, valid_rise_cyc = 0;
    logic        prev_fe = 1'b0, prev_ov = 1'b0, prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) begin
                fe_cnt <= fe_cnt + 1;
                fe_cyc <= cyc;
            end
            if (overrun) ov_cnt <= ov_cnt + 1;
            if ((frame_err && prev_fe) || (overrun && prev_ov)) long_pulse <= long_pulse + 1;
            if (frame_err && overrun) both <= both + 1;
            if (valid && !prev_valid) valid_rise_cyc <= cyc;
            if (valid) valid_seen <= valid_seen + 1;
            if (busy) busy_seen <= busy_seen + 1;
        end
        prev_fe    <= frame_err;
        prev_ov    <= overrun;
        prev_valid <= valid;
    end

    // Reference model: bytes the consumer should see, and how full the receive buffer is.
    logic [7:0] exp_q[$];
    int         model_fill = 0;
    int         exp_ov = 0;
    int unsigned start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs >= exp - 1 && obs <= exp + 1)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d +-1", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * CDIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx        = 1'b0;
        start_cyc = cyc;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = stop_bit;
        wait_bits(1);
        rx = 1'b1;
    endtask

    // A good frame lands in the buffer, or counts as an overrun when the buffer is full.
    task automatic model_good(input logic [7:0] b);
        if (ready) begin
            exp_q.push_back(b);
        end else if (model_fill < BUF) begin
            exp_q.push_back(b);
            model_fill++;
        end else begin
            exp_ov++;
        end
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, acc_q.size(), exp_q.size());
        while (acc_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_byte"}, acc_q.pop_front(), exp_q.pop_front());
        end
        acc_q.delete();
        acc_cyc.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        ready = 1'b1;
        repeat (BUF + 4) @(negedge clk);
        model_fill = 0;
    endtask

    int          fe0, ov0, vs0, bs0, n;
    logic [7:0]  b;
    int unsigned c0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b1;
        wait_bits(2);
        chk("idle_busy", busy, 1'b0);

        // Single byte, latency, then handshake
        send_frame(8'h67, 1'b1);
        model_good(8'h67);
        chk("g_valid", valid, 1'b1);
        chk("g_data", data, 8'h67);
        chk_near("g_latency", int'(valid_rise_cyc - start_cyc), LAT);
        ready = 1'b1;
        @(negedge clk);
        chk("g_valid_after_pop", valid, 1'b0);
        ready      = 1'b0;
        model_fill = 0;
        wait_bits(1);
        check_log("g");

        // Glitch shorter than half a bit
        fe0 = fe_cnt;
        vs0 = valid_seen;
        bs0 = busy_seen;
        rx  = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        wait_bits(2);
        chk("glitch_busy_rose", busy_seen > bs0, 1'b1);
        chk("glitch_busy_idle", busy, 1'b0);
        chk("glitch_no_valid", valid_seen, vs0);
        chk("glitch_no_fe", fe_cnt, fe0);

        // Framing error, then resynchronise on the next byte
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        c0 = start_cyc;
        wait_bits(2);
        chk("fe_pulse_count", fe_cnt, fe0 + 1);
        chk_near("fe_pulse_time", int'(fe_cyc - c0), LAT - 1);
        chk("fe_no_valid", valid, 1'b0);
        ready = 1'b1;
        send_frame(8'h41, 1'b1);
        model_good(8'h41);
        wait_bits(1);
        chk("fe_resync_fe", fe_cnt, fe0 + 1);
        check_log("fe_resync");
        ready = 1'b0;

        // Overrun on back-to-back frames, then a burst drain
        ov0    = ov_cnt;
        exp_ov = 0;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h31 + 8'(i), 1'b1);
            model_good(8'h31 + 8'(i));
        end
        wait_bits(1);
        chk("ovr_count", ov_cnt - ov0, exp_ov);
        chk("ovr_valid", valid, 1'b1);
        chk("ovr_head", data, 8'h31);
        drain();
        chk("ovr_drained", valid, 1'b0);
        chk("ovr_burst_len", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("ovr_consecutive", acc_cyc[i] - acc_cyc[i-1], 1);
        end
        check_log("ovr");

        // Reset during bit 4 of 0xA5
        b  = 8'hA5;
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = b[4];
        repeat (CDIV / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", valid, 1'b0);
        @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        acc_q.delete();
        exp_q.delete();
        model_fill = 0;
        wait_bits(2);
        send_frame(8'h5A, 1'b1);
        model_good(8'h5A);
        wait_bits(1);
        check_log("midrst_next");

        // Random bytes with ready held high and random idle gaps
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_good(b);
            n = $urandom_range(0, 2);
            if (n > 0) wait_bits(n);
        end
        wait_bits(1);
        check_log("rand_stream");

        // Random back-to-back bursts against a stalled consumer
        for (int k = 0; k < 3; k++) begin
            ready      = 1'b0;
            ov0        = ov_cnt;
            exp_ov     = 0;
            model_fill = 0;
            n          = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_frame(b, 1'b1);
                model_good(b);
            end
            wait_bits(1);
            chk("rand_burst_ovr", ov_cnt - ov0, exp_ov);
            drain();
            check_log("rand_burst");
        end

        chk("pulse_width", long_pulse, 0);
        chk("fe_ovr_exclusive", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
